dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue_pkg.sv | 20 ++
 rtl/dispatch_queue_compact.sv | 22 ++
 rtl/dispatch_queue.sv | 90 +++++++++
 tb/tb_dispatch_queue.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared backend constants and the dispatched-op payload layout used by the dispatch queue.
package dispatch_queue_pkg;

  localparam int DQ_WIDTH     = 4;
  localparam int DQ_OUT_WIDTH = 4;
  localparam int DQ_DEPTH     = 16;

  typedef struct packed {
    logic [21:0] op;
    logic [6:0]  prs1;
    logic [6:0]  prs2;
    logic [6:0]  prs3;
    logic [6:0]  prd;
    logic [6:0]  old_prd;
    logic [6:0]  rob_idx;
  } dis_op_t;

  localparam int DQ_DATA_W = $bits(dis_op_t);

endpackage

// File: rtl/dispatch_queue_compact.sv
// Prefix-count of the rename valid mask: each slot's offset from tail, plus total enqueue count.
module dispatch_compact #(
  parameter int WIDTH = 4,
  parameter int OW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         in_en,
  output logic [WIDTH-1:0][OW-1:0] offset,
  output logic [OW-1:0]            enq_num
);

  always_comb begin
    logic [OW-1:0] acc;
    acc    = '0;
    offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = acc;
      acc       = acc + OW'(in_en[i]);
    end
    enq_num = acc;
  end

endmodule

// File: rtl/dispatch_queue.sv
// Circular dispatch queue between rename and issue: compacting multi-op enqueue, in-order multi-op dequeue.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int WIDTH     = DQ_WIDTH,
  parameter int OUT_WIDTH = DQ_OUT_WIDTH,
  parameter int DEPTH     = DQ_DEPTH,
  parameter int DATA_W    = DQ_DATA_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  in_en,
  input  logic [WIDTH-1:0][DATA_W-1:0]      in_data,
  input  logic                              redirect,
  output logic                              dis_full,
  output logic [OUT_WIDTH-1:0]              out_valid,
  output logic [OUT_WIDTH-1:0][DATA_W-1:0]  out_data,
  input  logic [OUT_WIDTH-1:0]              out_ready,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              dis_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(OUT_WIDTH + 1);

  // Pointers carry a dir bit in the MSB; occupancy is their difference.
  logic [AW:0]             head_q, head_d, tail_q, tail_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0][OW-1:0] offset;
  logic [OW-1:0]           enq_num;
  logic [DW-1:0]           deq_num;
  logic                    enq_fire;

  dispatch_compact #(.WIDTH(WIDTH), .OW(OW)) u_compact (
    .in_en   (in_en),
    .offset  (offset),
    .enq_num (enq_num)
  );

  assign count     = tail_q - head_q;
  assign dis_full  = count > (AW+1)'(DEPTH - WIDTH);
  assign enq_fire  = (|in_en) & ~dis_full & ~redirect;
  assign dis_stall = (|in_en) & dis_full;

  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_out
    assign out_valid[i] = (AW+1)'(i) < count;
    assign out_data[i]  = mem_q[AW'(head_q[AW-1:0] + AW'(i))];
  end

  // Only the leading run of accepted slots leaves; readies past a gap are ignored.
  always_comb begin
    logic stop;
    stop    = 1'b0;
    deq_num = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (!stop && out_valid[i] && out_ready[i]) deq_num = deq_num + DW'(1);
      else                                       stop    = 1'b1;
    end
  end

  always_comb begin
    head_d = head_q + (AW+1)'(deq_num);
    tail_d = tail_q + (enq_fire ? (AW+1)'(enq_num) : '0);
    if (redirect) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Payload is not reset; out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_en[i]) mem_q[AW'(tail_q[AW-1:0] + AW'(offset[i]))] <= in_data[i];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue at WIDTH=4, OUT_WIDTH=4, DEPTH=16.
module tb_dispatch_queue;

  localparam int W  = 4;
  localparam int OW = 4;
  localparam int D  = 16;
  localparam int DW = 64;

  logic                     clk, rst, redirect, dis_full, dis_stall;
  logic [W-1:0]             in_en;
  logic [W-1:0][DW-1:0]     in_data;
  logic [OW-1:0]            out_valid, out_ready;
  logic [OW-1:0][DW-1:0]    out_data;
  logic [$clog2(D):0]       count;

  int n_cmp = 0;
  int n_err = 0;

  dispatch_queue #(.WIDTH(W), .OUT_WIDTH(OW), .DEPTH(D), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_data   (in_data),
    .redirect  (redirect),
    .dis_full  (dis_full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .dis_stall (dis_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slot i carries base+i so expected payloads follow directly from the base.
  task automatic drive(input logic [3:0] en, input logic [63:0] base,
                       input logic [3:0] rdy, input logic redir);
    in_en     = en;
    out_ready = rdy;
    redirect  = redir;
    for (int i = 0; i < W; i++) in_data[i] = base + 64'(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_en     = '0;
    out_ready = '0;
    redirect  = 1'b0;
    in_data   = '0;
  endtask

  task automatic cyc(input logic [3:0] en, input logic [63:0] base,
                     input logic [3:0] rdy, input logic redir);
    drive(en, base, rdy, redir);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    drive(4'b0000, 64'h0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count",     64'(count),     64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_dis_full",  64'(dis_full),  64'd0);
    rst = 1'b1;

    // Sparse enqueue: A in slot 1, B in slot 3; not visible until the next cycle.
    drive(4'b1010, 64'hA0, 4'b0000, 1'b0);
    #1;
    chk("no_bypass_valid", 64'(out_valid), 64'd0);
    tick();
    chk("sparse_count", 64'(count),     64'd2);
    chk("sparse_valid", 64'(out_valid), 64'b0011);
    chk("sparse_data0", out_data[0],    64'hA1);
    chk("sparse_data1", out_data[1],    64'hA3);

    // Partial dequeue at count=4: slots 0,1 accept, slot 2 stalls, slot 3 ready ignored.
    cyc(4'b0011, 64'hC0, 4'b0000, 1'b0);
    chk("pdeq_pre_count", 64'(count), 64'd4);
    cyc(4'b0000, 64'h0, 4'b1011, 1'b0);
    chk("pdeq_count", 64'(count),     64'd2);
    chk("pdeq_valid", 64'(out_valid), 64'b0011);
    chk("pdeq_data0", out_data[0],    64'hC0);
    chk("pdeq_data1", out_data[1],    64'hC1);

    // Redirect at count=8 wins over same-cycle enqueue and dequeue.
    cyc(4'b1111, 64'hD0, 4'b0000, 1'b0);
    cyc(4'b0011, 64'hE0, 4'b0000, 1'b0);
    chk("redir_pre_count", 64'(count), 64'd8);
    cyc(4'b1111, 64'hF0, 4'b1111, 1'b1);
    chk("redir_count", 64'(count),     64'd0);
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_full",  64'(dis_full),  64'd0);

    // Full threshold: 12 is still open, 16 and 13 are full.
    cyc(4'b1111, 64'h10, 4'b0000, 1'b0);
    cyc(4'b1111, 64'h20, 4'b0000, 1'b0);
    cyc(4'b1111, 64'h30, 4'b0000, 1'b0);
    chk("c12_count", 64'(count),    64'd12);
    chk("c12_full",  64'(dis_full), 64'd0);
    cyc(4'b1111, 64'h40, 4'b0000, 1'b0);
    chk("c16_count", 64'(count),    64'd16);
    chk("c16_full",  64'(dis_full), 64'd1);
    chk("c16_data0", out_data[0],   64'h10);
    cyc(4'b0000, 64'h0, 4'b0111, 1'b0);
    chk("c13_count", 64'(count),    64'd13);
    chk("c13_full",  64'(dis_full), 64'd1);
    drive(4'b1111, 64'h50, 4'b0000, 1'b0);
    #1;
    chk("c13_stall", 64'(dis_stall), 64'd1);
    tick();
    chk("c13_hold_count", 64'(count),  64'd13);
    chk("c13_hold_data0", out_data[0], 64'h13);

    // Walk head/tail to 14, then enqueue 4 across the 15->0 wrap.
    cyc(4'b0000, 64'h0, 4'b0000, 1'b1);
    cyc(4'b1111, 64'h60, 4'b0000, 1'b0);
    cyc(4'b1111, 64'h70, 4'b0000, 1'b0);
    cyc(4'b1111, 64'h80, 4'b0000, 1'b0);
    cyc(4'b0011, 64'h90, 4'b0000, 1'b0);
    chk("c14_count", 64'(count), 64'd14);
    repeat (4) cyc(4'b0000, 64'h0, 4'b1111, 1'b0);
    chk("drain_count", 64'(count),     64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    cyc(4'b1111, 64'hB0, 4'b0000, 1'b0);
    chk("wrap_count", 64'(count),     64'd4);
    chk("wrap_valid", 64'(out_valid), 64'b1111);
    chk("wrap_data0", out_data[0],    64'hB0);
    chk("wrap_data1", out_data[1],    64'hB1);
    chk("wrap_data2", out_data[2],    64'hB2);
    chk("wrap_data3", out_data[3],    64'hB3);

    // Simultaneous enqueue 4 / dequeue 2; new ops land at index 2 after the wrapped tail.
    cyc(4'b1111, 64'hC8, 4'b0011, 1'b0);
    chk("sim_count", 64'(count),  64'd6);
    chk("sim_data0", out_data[0], 64'hB2);
    chk("sim_data1", out_data[1], 64'hB3);
    chk("sim_data2", out_data[2], 64'hC8);
    chk("sim_data3", out_data[3], 64'hC9);

    // Asynchronous reset at count=10, then a fresh 3-op enqueue.
    cyc(4'b1111, 64'hD8, 4'b0000, 1'b0);
    chk("c10_count", 64'(count), 64'd10);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_count", 64'(count),     64'd0);
    chk("async_rst_full",  64'(dis_full),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(4'b0111, 64'hE8, 4'b0000, 1'b0);
    chk("post_rst_count", 64'(count),     64'd3);
    chk("post_rst_valid", 64'(out_valid), 64'b0111);
    chk("post_rst_data0", out_data[0],    64'hE8);
    chk("post_rst_data2", out_data[2],    64'hEA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
